// File: rtl/jpeg_qf_ctrl.sv
// Capture sequencer for the JPEG encoder: issues capture pulses, walks the QF
// down when the compressed image exceeds the byte budget, and reports the result.
module jpeg_qf_ctrl #(
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int MAX_ATTEMPTS   = 4
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        cmd_start_in,
    input  logic        cmd_abort_in,
    input  logic        auto_qf_en_in,
    input  logic [1:0]  qf_init_in,
    input  logic [15:0] size_budget_in,
    input  logic        image_valid_in,
    input  logic [15:0] address_in,
    output logic        start_capture_out,
    output logic [1:0]  qf_select_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [1:0]  status_out,
    output logic [15:0] final_size_out,
    output logic [1:0]  final_qf_out,
    output logic [2:0]  attempts_out,
    output logic [2:0]  state_dbg_out
);

    // Handshake: cmd_start_in/cmd_abort_in are single-cycle pulses with no ready;
    // start is only accepted in IDLE, abort only outside IDLE. start_capture_out
    // and done_out are single-cycle pulses; image_valid_in is a level.
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] ATT_MAX = 3'(MAX_ATTEMPTS);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_OVERSIZE = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_ABORTED  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_CLEAR,
        S_WAIT_IMAGE,
        S_CHECK
    } state_t;

    state_t        state;
    logic [15:0]   budget_r;
    logic [15:0]   size_r;
    logic          auto_r;
    logic          abort_pend;
    logic [2:0]    attempts;
    logic [TW-1:0] tmo_cnt;

    assign state_dbg_out = state;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state             <= S_IDLE;
            start_capture_out <= 1'b0;
            qf_select_out     <= 2'd0;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            status_out        <= 2'd0;
            final_size_out    <= 16'd0;
            final_qf_out      <= 2'd0;
            attempts_out      <= 3'd0;
            budget_r          <= 16'd0;
            size_r            <= 16'd0;
            auto_r            <= 1'b0;
            abort_pend        <= 1'b0;
            attempts          <= 3'd0;
            tmo_cnt           <= '0;
        end else begin
            start_capture_out <= 1'b0;
            done_out          <= 1'b0;
            if (state != S_IDLE && cmd_abort_in) begin
                abort_pend <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (cmd_start_in) begin
                        budget_r          <= size_budget_in;
                        auto_r            <= auto_qf_en_in;
                        qf_select_out     <= qf_init_in;
                        attempts          <= 3'd0;
                        abort_pend        <= 1'b0;
                        start_capture_out <= 1'b1;
                        busy_out          <= 1'b1;
                        state             <= S_START;
                    end
                end
                S_START: begin
                    attempts <= attempts + 3'd1;
                    tmo_cnt  <= '0;
                    state    <= S_WAIT_CLEAR;
                end
                S_WAIT_CLEAR: begin
                    if (tmo_cnt == TMO_LAST) begin
                        status_out     <= ST_TIMEOUT;
                        final_size_out <= 16'd0;
                        final_qf_out   <= qf_select_out;
                        attempts_out   <= attempts;
                        done_out       <= 1'b1;
                        busy_out       <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        // The encoder holds image_valid from the previous frame until it restarts.
                        if (!image_valid_in) begin
                            state <= S_WAIT_IMAGE;
                        end
                    end
                end
                S_WAIT_IMAGE: begin
                    if (image_valid_in) begin
                        size_r <= address_in;
                        state  <= S_CHECK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        status_out     <= ST_TIMEOUT;
                        final_size_out <= 16'd0;
                        final_qf_out   <= qf_select_out;
                        attempts_out   <= attempts;
                        done_out       <= 1'b1;
                        busy_out       <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (abort_pend || cmd_abort_in || size_r <= budget_r ||
                        !auto_r || qf_select_out == 2'd3 || attempts == ATT_MAX) begin
                        if (abort_pend || cmd_abort_in) begin
                            status_out <= ST_ABORTED;
                        end else if (size_r <= budget_r) begin
                            status_out <= ST_OK;
                        end else begin
                            status_out <= ST_OVERSIZE;
                        end
                        final_size_out <= size_r;
                        final_qf_out   <= qf_select_out;
                        attempts_out   <= attempts;
                        done_out       <= 1'b1;
                        busy_out       <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        // Retry one step lower in quality; QF settles with the start pulse.
                        qf_select_out     <= qf_select_out + 2'd1;
                        start_capture_out <= 1'b1;
                        state             <= S_START;
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
